io_ctrl: RTL

Sequencer for the 8-bit I/O register block (port register plus data register, shared port and data buses). It accepts one IN or OUT command at a time from the CPU control unit and generates the io register strobes (port_in, in_en, port_out, out_en, clr) in the correct order. It runs a four-phase req/ack handshake with the external peripheral and reports done or err back to the CPU. It sits between the control unit and the io register, and is idle and locked out while program_mode is high.

---
 rtl/io_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/io_ctrl.sv
// Sequencer for the 8-bit I/O register block: orders the io register strobes for
// one IN/OUT command and runs a four-phase req/ack handshake with the peripheral.
module io_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic program_mode,
  input  logic cmd_valid,
  input  logic cmd_wr,
  input  logic cmd_rd,
  output logic cmd_ready,
  output logic done,
  output logic err,
  output logic port_in,
  output logic in_en,
  output logic port_out,
  output logic out_en,
  output logic clr,
  output logic ext_req,
  output logic ext_dir,
  input  logic ext_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_PORT, S_LD_DATA, S_WAIT_ACK, S_CAPTURE, S_RELEASE, S_DONE, S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic             wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_wait_q, in_release_q;

  assign cmd_ready    = (state_q == S_IDLE) && !program_mode;
  assign in_wait_q    = (state_q == S_WAIT_ACK);
  assign in_release_q = (state_q == S_RELEASE);

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_ready && cmd_valid) begin
          if (cmd_wr && cmd_rd) begin
            state_d = S_ERR;
          end else if (cmd_wr || cmd_rd) begin
            state_d = S_LD_PORT;
            wr_d    = cmd_wr;
          end
        end
      end
      S_LD_PORT:  state_d = wr_q ? S_LD_DATA : S_WAIT_ACK;
      S_LD_DATA:  state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        // A sampled ack wins over the timeout on the last allowed cycle.
        if (ext_ack)                 state_d = wr_q ? S_RELEASE : S_CAPTURE;
        else if (cnt_q == CNT_LAST)  state_d = S_ERR;
      end
      S_CAPTURE:  state_d = S_RELEASE;
      S_RELEASE: begin
        if (!ext_ack)                state_d = S_DONE;
        else if (cnt_q == CNT_LAST)  state_d = S_ERR;
      end
      S_DONE:     state_d = S_IDLE;
      S_ERR:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Counter restarts on entry to each waiting phase and saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d == S_WAIT_ACK && !in_wait_q) || (state_d == S_RELEASE && !in_release_q)) begin
      cnt_d = '0;
    end else if ((in_wait_q || in_release_q) && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: outputs are registered from the next-state decode, so each one is a flop
  // that exactly tracks the Moore decode of state_q and clears with the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      clr      <= 1'b0;
      port_in  <= 1'b0;
      in_en    <= 1'b0;
      port_out <= 1'b0;
      out_en   <= 1'b0;
      ext_req  <= 1'b0;
      ext_dir  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      done     <= (state_d == S_DONE);
      err      <= (state_d == S_ERR);
      clr      <= (state_d == S_ERR);
      port_in  <= (state_d == S_LD_PORT);
      in_en    <= (state_d == S_LD_DATA) || (state_d == S_CAPTURE);
      port_out <= (state_d == S_WAIT_ACK) || (state_d == S_CAPTURE);
      out_en   <= ((state_d == S_WAIT_ACK) && wr_d) || ((state_d == S_DONE) && !wr_d);
      ext_req  <= (state_d == S_WAIT_ACK) || (state_d == S_CAPTURE);
      ext_dir  <= wr_d && (state_d inside {S_LD_PORT, S_LD_DATA, S_WAIT_ACK, S_CAPTURE,
                                           S_RELEASE, S_DONE});
    end
  end

endmodule
